// File: rtl/norm_acc.sv
// norm_acc: Euclidean norm / sum-of-squares accumulator.
//
// Squares and accumulates N unsigned W-bit channels, one channel per cycle.
// In mode 0 it then takes the integer square root bit-serially. In mode 1 it
// returns the raw sum of squares. The result is held on y_bo until the next
// operation completes.
//
// State table:
//   state  | code | meaning
//   IDLE   | 0    | waiting for start_i; latches x_bi/mode_i on start
//   SQUARE | 1    | adding x_i*x_i for channel i = 0..N-1, one per cycle
//   ROOT   | 2    | restoring square root, one result bit per cycle
//   DONE   | 3    | y_bo freshly loaded, valid_o high for one cycle
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous reset, active low
//   start_i  in   start request, sampled only in IDLE
//   mode_i   in   0 = norm, 1 = sum of squares (sampled with start_i)
//   x_bi     in   N packed W-bit channels, channel 0 in the LSBs
//   y_bo     out  result, zero-extended to S bits
//   state_o  out  current state code
//   busy_o   out  high in SQUARE and ROOT
//   valid_o  out  high in DONE

module norm_acc #(
    parameter int W = 8,
    parameter int N = 2,
    localparam int S = 2 * W + $clog2(N),
    localparam int R = (S + 1) / 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic           mode_i,
    input  logic [N*W-1:0] x_bi,
    output logic [S-1:0]   y_bo,
    output logic [2:0]     state_o,
    output logic           busy_o,
    output logic           valid_o
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SQUARE = 3'd1;
    localparam logic [2:0] ROOT   = 3'd2;
    localparam logic [2:0] DONE   = 3'd3;

    localparam int MAXC = (N > R) ? N : R;
    localparam int CW   = $clog2(MAXC + 1);

    // The accumulator is 2*R bits wide so it can double as the root's
    // running remainder.
    localparam logic [2*R-1:0] BIT_INIT = (2*R)'(1) << (2 * R - 2);

    logic [2:0]     state_q, state_d;
    logic [N*W-1:0] x_q;
    logic           mode_q;
    logic [2*R-1:0] acc_q;
    logic [2*R-1:0] res_q;
    logic [2*R-1:0] bit_q;
    logic [CW-1:0]  cnt_q;
    logic [S-1:0]   y_q;

    logic [2*W-1:0] chan_ext;
    logic [2*W-1:0] sq;
    logic [2*R-1:0] acc_sum;
    logic [2*R-1:0] trial;
    logic           fits;
    logic [2*R-1:0] res_next;
    logic [2*R-1:0] rem_next;
    logic           last;

    // Latched channels shift down by W each SQUARE cycle, so channel i sits
    // in the low bits on cycle i.
    assign chan_ext = (2*W)'(x_q[W-1:0]);
    assign sq       = chan_ext * chan_ext;
    assign acc_sum  = acc_q + (2*R)'(sq);
    assign last     = (cnt_q == '0);

    // Digit-by-digit root: bit_q walks down the powers of four. The result
    // bit is kept only if the remainder covers res + bit. Only adds,
    // subtracts and shifts are used here.
    assign trial    = res_q + bit_q;
    assign fits     = (acc_q >= trial);
    assign res_next = fits ? ((res_q >> 1) + bit_q) : (res_q >> 1);
    assign rem_next = fits ? (acc_q - trial) : acc_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = start_i ? SQUARE : IDLE;
            SQUARE:  state_d = last ? (mode_q ? DONE : ROOT) : SQUARE;
            ROOT:    state_d = last ? DONE : ROOT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        state_o = state_q;
        busy_o  = (state_q == SQUARE) || (state_q == ROOT);
        valid_o = (state_q == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            x_q    <= '0;
            mode_q <= 1'b0;
            acc_q  <= '0;
            res_q  <= '0;
            bit_q  <= '0;
            cnt_q  <= '0;
            y_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        x_q    <= x_bi;
                        mode_q <= mode_i;
                        acc_q  <= '0;
                        res_q  <= '0;
                        cnt_q  <= CW'(N - 1);
                    end
                end
                SQUARE: begin
                    acc_q <= acc_sum;
                    x_q   <= x_q >> W;
                    if (last) begin
                        cnt_q <= CW'(R - 1);
                        bit_q <= BIT_INIT;
                        if (mode_q) begin
                            y_q <= acc_sum[S-1:0];
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ROOT: begin
                    acc_q <= rem_next;
                    res_q <= res_next;
                    bit_q <= bit_q >> 2;
                    cnt_q <= cnt_q - CW'(1);
                    if (last) begin
                        y_q <= S'(res_next);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign y_bo = y_q;

endmodule

// File: tb/tb_norm_acc.sv
module tb_norm_acc;

    localparam int W   = 8;
    localparam int NA  = 2;
    localparam int NB  = 4;
    localparam int SA  = 17;
    localparam int SB  = 18;
    localparam int RA  = 9;
    localparam int RB  = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_a, start_b, mode;
    logic [NA*W-1:0] x_a;
    logic [NB*W-1:0] x_b;
    logic [SA-1:0] y_a;
    logic [SB-1:0] y_b;
    logic [2:0]    st_a, st_b;
    logic          busy_a, busy_b, vld_a, vld_b;
    logic          pv_a = 1'b0;
    logic          pv_b = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int q_a[$];
    int q_b[$];
    int last_a = 0;

    norm_acc #(.W(W), .N(NA)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .start_i(start_a), .mode_i(mode),
        .x_bi(x_a), .y_bo(y_a), .state_o(st_a), .busy_o(busy_a), .valid_o(vld_a)
    );

    norm_acc #(.W(W), .N(NB)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .start_i(start_b), .mode_i(mode),
        .x_bi(x_b), .y_bo(y_b), .state_o(st_b), .busy_o(busy_b), .valid_o(vld_b)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Scoreboard side: every valid pulse pops one expected result.
    always @(negedge clk) begin
        if (vld_a) begin
            chk("valid_width_a", pv_a, 0);
            if (q_a.size() == 0) chk("valid_without_op_a", 32'(q_a.size()), 1);
            else chk("y_a", y_a, q_a.pop_front());
        end
        if (vld_b) begin
            chk("valid_width_b", pv_b, 0);
            if (q_b.size() == 0) chk("valid_without_op_b", 32'(q_b.size()), 1);
            else chk("y_b", y_b, q_b.pop_front());
        end
        pv_a <= vld_a;
        pv_b <= vld_b;
    end

    task automatic op_a(input bit m, input logic [7:0] x0, input logic [7:0] x1, input bit hold);
        int s, e, c, lat;
        s = int'(x0) * int'(x0) + int'(x1) * int'(x1);
        e = m ? s : isqrt(s);
        lat = m ? NA : NA + RA;
        q_a.push_back(e);
        mode = m; x_a = {x1, x0}; start_a = 1'b1;
        @(posedge clk); #1;
        if (!hold) start_a = 1'b0;
        x_a = 16'($urandom);
        mode = ~m;
        c = 0;
        @(negedge clk);
        while (!vld_a && c < 40) begin
            chk("state_a", st_a, (c < NA) ? 1 : 2);
            chk("busy_a", busy_a, 1);
            chk("hold_y_a", y_a, last_a);
            @(negedge clk);
            c++;
        end
        chk("latency_a", c, lat);
        chk("state_done_a", st_a, 3);
        last_a = e;
        @(negedge clk);
        chk("idle_after_done_a", st_a, 0);
    endtask

    task automatic op_b(input bit m, input logic [31:0] xv);
        int s, e, c;
        s = 0;
        for (int i = 0; i < NB; i++) s += int'(xv[i*8 +: 8]) * int'(xv[i*8 +: 8]);
        e = m ? s : isqrt(s);
        q_b.push_back(e);
        mode = m; x_b = xv; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        x_b = $urandom;
        mode = ~m;
        c = 0;
        @(negedge clk);
        while (!vld_b && c < 40) begin
            chk("busy_b", busy_b, 1);
            start_b = (c == 3);
            @(negedge clk);
            c++;
        end
        start_b = 1'b0;
        chk("latency_b", c, m ? NB : NB + RB);
        chk("state_done_b", st_b, 3);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; mode = 1'b0;
        x_a = '0; x_b = '0;
        #12;
        chk("rst_state", st_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_valid", vld_a, 0);
        chk("rst_y", y_a, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        op_a(0, 8'd4, 8'd3, 0);
        op_a(1, 8'd255, 8'd255, 0);
        op_a(0, 8'd255, 8'd255, 0);
        op_a(0, 8'd0, 8'd0, 0);
        op_a(1, 8'd0, 8'd0, 0);

        // Abort during the third ROOT cycle.
        q_a.push_back(5);
        mode = 1'b0; x_a = {8'd3, 8'd4}; start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("in_root_a", st_a, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", st_a, 0);
        chk("async_rst_busy", busy_a, 0);
        chk("async_rst_valid", vld_a, 0);
        chk("async_rst_y", y_a, 0);
        void'(q_a.pop_back());
        last_a = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (15) @(negedge clk);
        op_a(0, 8'd4, 8'd3, 0);

        for (int i = 0; i < 3; i++) op_a(0, 8'($urandom), 8'($urandom), 1);
        start_a = 1'b0;

        op_b(0, 32'hFFFF_FFFF);
        op_b(1, $urandom);
        op_b(0, $urandom);

        repeat (4) @(negedge clk);
        chk("queue_a_drained", 32'(q_a.size()), 0);
        chk("queue_b_drained", 32'(q_b.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
